md_sequencer: RTL and testbench

//  Multi-cycle multiply/divide unit and its sequencer, in the E stage beside the ALU.

---
 rtl/md_sequencer_if.sv | 34 +++
 rtl/md_sequencer.sv | 123 ++++++++++++
 tb/tb_md_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/md_sequencer_if.sv
// rtl/md_sequencer_if.sv - E-stage multiply/divide unit handshake and HI/LO bundle
//
// Purpose: groups the issue, flush and stall signals of the md unit.
// Ports (master = pipeline side, slave = md_sequencer):
//   start    master->slave  E-stage instruction is an md op
//   md_op    master->slave  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no-op
//   A, B     master->slave  forwarded rs / rt operands
//   req      master->slave  exception/interrupt taken; squashes start
//   md_D     master->slave  D-stage instruction uses HI/LO
//   busy     slave->master  mult/div in flight
//   md_stall slave->master  D-stage stall request
//   HI, LO   slave->master  architectural HI/LO registers
interface md_sequencer_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        req;
    logic        md_D;
    logic        busy;
    logic        md_stall;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, md_op, A, B, req, md_D,
        input  busy, md_stall, HI, LO
    );

    modport slave (
        input  start, md_op, A, B, req, md_D,
        output busy, md_stall, HI, LO
    );
endinterface

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - multi-cycle multiply/divide unit and HI/LO sequencer
//
// Purpose: accepts one md op per start pulse, computes the result at accept
// time, holds busy for a fixed latency, then commits HI/LO. mthi/mtlo write
// directly on the accept edge. A flush (req) on the start cycle squashes the op.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   md     md_sequencer_if.slave (start, md_op, A, B, req, md_D in;
//          busy, md_stall, HI, LO out)
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           reset,
    md_sequencer_if.slave  md
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_next;
    logic [CW-1:0] counter;
    logic [31:0]   temp_hi, temp_lo;
    logic [31:0]   hi_q, lo_q;
    logic          busy;
    logic          acc;
    logic          md_start;

    logic [63:0]        prod_s, prod_u;
    logic signed [31:0] a_s, b_s;
    logic [31:0]        res_hi, res_lo;

    assign busy     = (state == RUN);
    assign acc      = md.start && !md.req && !busy;
    // ops 0..3 are the multi-cycle mult/div group
    assign md_start = acc && (md.md_op[2] == 1'b0);

    assign md.busy     = busy;
    assign md.md_stall = md.md_D && (busy || md.start);
    assign md.HI       = hi_q;
    assign md.LO       = lo_q;

    assign a_s    = $signed(md.A);
    assign b_s    = $signed(md.B);
    assign prod_s = $signed({{32{md.A[31]}}, md.A}) * $signed({{32{md.B[31]}}, md.B});
    assign prod_u = {32'd0, md.A} * {32'd0, md.B};

    // Result is formed at accept time; the busy window only models latency.
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (md.md_op[1:0])
            2'd0: {res_hi, res_lo} = prod_s;
            2'd1: {res_hi, res_lo} = prod_u;
            2'd2: begin
                if (md.B == 32'd0) begin
                    res_lo = 32'hFFFF_FFFF;
                    res_hi = md.A;
                end else if (md.A == 32'h8000_0000 && md.B == 32'hFFFF_FFFF) begin
                    // quotient would not fit in 32 bits
                    res_lo = 32'h8000_0000;
                    res_hi = 32'd0;
                end else begin
                    res_lo = $unsigned(a_s / b_s);
                    res_hi = $unsigned(a_s % b_s);
                end
            end
            default: begin
                if (md.B == 32'd0) begin
                    res_lo = 32'hFFFF_FFFF;
                    res_hi = md.A;
                end else begin
                    res_lo = md.A / md.B;
                    res_hi = md.A % md.B;
                end
            end
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (md_start) state_next = RUN;
            RUN:     if (counter == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            temp_hi <= 32'd0;
            temp_lo <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state <= state_next;
            if (md_start) begin
                temp_hi <= res_hi;
                temp_lo <= res_lo;
                counter <= md.md_op[1] ? DIV_LOAD : MULT_LOAD;
            end else if (state == RUN) begin
                if (counter == '0) begin
                    hi_q <= temp_hi;
                    lo_q <= temp_lo;
                end else begin
                    counter <= counter - 1'b1;
                end
            end
            // acc implies IDLE, so these never collide with the RUN commit
            if (acc && md.md_op == 3'd4) hi_q <= md.A;
            if (acc && md.md_op == 3'd5) lo_q <= md.A;
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// tb/tb_md_sequencer.sv - directed self-checking bench for md_sequencer
module tb_md_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    md_sequencer_if md();

    md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md)
    );

    task automatic drive_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic rq);
        md.start = 1'b1;
        md.md_op = op;
        md.A     = a;
        md.B     = b;
        md.req   = rq;
        @(negedge clk);
        md.start = 1'b0;
        md.req   = 1'b0;
        md.md_op = 3'd7;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (md.busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        md.start = 1'b0; md.md_op = 3'd7; md.A = '0; md.B = '0; md.req = 1'b0; md.md_D = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        total++; if (md.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", md.busy); end
        total++; if (md.HI !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=0", md.HI); end
        total++; if (md.LO !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=0", md.LO); end
        total++; if (md.md_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", md.md_stall); end
    endtask

    task automatic test_mult;
        int n;
        drive_op(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
        total++; if (md.busy !== 1'b1) begin bad++; $display("FAIL mult_busy_rise got=%0b want=1", md.busy); end
        count_busy(n);
        total++; if (n != 5) begin bad++; $display("FAIL mult_busy_len got=%0d want=5", n); end
        total++; if (md.HI !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h want=ffffffff", md.HI); end
        total++; if (md.LO !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mult_lo got=%h want=ffffffeb", md.LO); end
    endtask

    task automatic test_divu_stall;
        int stalls;
        int guard;
        md.md_D  = 1'b1;
        md.start = 1'b1; md.md_op = 3'd3; md.A = 32'd100; md.B = 32'd7; md.req = 1'b0;
        #1;
        stalls = (md.md_stall === 1'b1) ? 1 : 0;
        @(negedge clk);
        md.start = 1'b0; md.md_op = 3'd7;
        guard = 0;
        while (md.busy === 1'b1 && guard < 40) begin
            if (md.md_stall === 1'b1) stalls++;
            guard++;
            @(negedge clk);
        end
        total++; if (stalls != 11) begin bad++; $display("FAIL divu_stall_cycles got=%0d want=11", stalls); end
        total++; if (md.md_stall !== 1'b0) begin bad++; $display("FAIL divu_stall_after got=%0b want=0", md.md_stall); end
        md.md_D = 1'b0;
        total++; if (md.LO !== 32'd14) begin bad++; $display("FAIL divu_lo got=%h want=0000000e", md.LO); end
        total++; if (md.HI !== 32'd2) begin bad++; $display("FAIL divu_hi got=%h want=00000002", md.HI); end
    endtask

    task automatic test_div_signed;
        logic [31:0] va[3], vb[3], elo[3], ehi[3];
        int n;
        va[0] = 32'hFFFF_FFF9; vb[0] = 32'd2;          elo[0] = 32'hFFFF_FFFD; ehi[0] = 32'hFFFF_FFFF;
        va[1] = 32'd5;         vb[1] = 32'd0;          elo[1] = 32'hFFFF_FFFF; ehi[1] = 32'd5;
        va[2] = 32'h8000_0000; vb[2] = 32'hFFFF_FFFF;  elo[2] = 32'h8000_0000; ehi[2] = 32'd0;
        for (int i = 0; i < 3; i++) begin
            drive_op(3'd2, va[i], vb[i], 1'b0);
            count_busy(n);
            total++; if (n != 10) begin bad++; $display("FAIL div_len[%0d] got=%0d want=10", i, n); end
            total++; if (md.LO !== elo[i]) begin bad++; $display("FAIL div_lo[%0d] got=%h want=%h", i, md.LO, elo[i]); end
            total++; if (md.HI !== ehi[i]) begin bad++; $display("FAIL div_hi[%0d] got=%h want=%h", i, md.HI, ehi[i]); end
        end
    endtask

    task automatic test_multu_req;
        int n;
        drive_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        count_busy(n);
        total++; if (md.HI !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi got=%h want=fffffffe", md.HI); end
        total++; if (md.LO !== 32'd1) begin bad++; $display("FAIL multu_lo got=%h want=00000001", md.LO); end
        drive_op(3'd0, 32'd5, 32'd6, 1'b1);
        total++; if (md.busy !== 1'b0) begin bad++; $display("FAIL req_busy got=%0b want=0", md.busy); end
        repeat (6) @(negedge clk);
        total++; if (md.HI !== 32'hFFFF_FFFE) begin bad++; $display("FAIL req_hi got=%h want=fffffffe", md.HI); end
        total++; if (md.LO !== 32'd1) begin bad++; $display("FAIL req_lo got=%h want=00000001", md.LO); end
        drive_op(3'd6, 32'd9, 32'd9, 1'b0);
        total++; if (md.busy !== 1'b0) begin bad++; $display("FAIL noop_busy got=%0b want=0", md.busy); end
        total++; if (md.LO !== 32'd1) begin bad++; $display("FAIL noop_lo got=%h want=00000001", md.LO); end
    endtask

    task automatic test_reset_midflight;
        drive_op(3'd2, 32'd100, 32'd7, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (md.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", md.busy); end
        total++; if (md.HI !== 32'd0) begin bad++; $display("FAIL rst_hi got=%h want=0", md.HI); end
        total++; if (md.LO !== 32'd0) begin bad++; $display("FAIL rst_lo got=%h want=0", md.LO); end
        repeat (12) @(negedge clk);
        total++; if (md.busy !== 1'b0) begin bad++; $display("FAIL rst_late_busy got=%0b want=0", md.busy); end
        total++; if (md.LO !== 32'd0) begin bad++; $display("FAIL rst_late_lo got=%h want=0", md.LO); end
        total++; if (md.HI !== 32'd0) begin bad++; $display("FAIL rst_late_hi got=%h want=0", md.HI); end
    endtask

    task automatic test_mthi_mtlo;
        drive_op(3'd5, 32'h1234, 32'd0, 1'b0);
        total++; if (md.LO !== 32'h1234) begin bad++; $display("FAIL mtlo_lo got=%h want=00001234", md.LO); end
        total++; if (md.HI !== 32'd0) begin bad++; $display("FAIL mtlo_hi got=%h want=0", md.HI); end
        total++; if (md.busy !== 1'b0) begin bad++; $display("FAIL mtlo_busy got=%0b want=0", md.busy); end
        drive_op(3'd4, 32'hABCD, 32'd0, 1'b1);
        total++; if (md.HI !== 32'd0) begin bad++; $display("FAIL mthi_req_hi got=%h want=0", md.HI); end
        drive_op(3'd4, 32'h55, 32'd0, 1'b0);
        total++; if (md.HI !== 32'h55) begin bad++; $display("FAIL mthi_hi got=%h want=00000055", md.HI); end
        total++; if (md.LO !== 32'h1234) begin bad++; $display("FAIL mthi_lo got=%h want=00001234", md.LO); end
    endtask

    task automatic test_back_to_back;
        int n;
        drive_op(3'd0, 32'd3, 32'd4, 1'b0);
        count_busy(n);
        total++; if (n != 5) begin bad++; $display("FAIL b2b_len0 got=%0d want=5", n); end
        total++; if (md.LO !== 32'd12) begin bad++; $display("FAIL b2b_lo0 got=%h want=0000000c", md.LO); end
        drive_op(3'd0, 32'd5, 32'd6, 1'b0);
        total++; if (md.busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%0b want=1", md.busy); end
        count_busy(n);
        total++; if (n != 5) begin bad++; $display("FAIL b2b_len1 got=%0d want=5", n); end
        total++; if (md.LO !== 32'd30) begin bad++; $display("FAIL b2b_lo1 got=%h want=0000001e", md.LO); end
        total++; if (md.HI !== 32'd0) begin bad++; $display("FAIL b2b_hi1 got=%h want=0", md.HI); end
    endtask

    initial begin
        test_reset;
        test_mult;
        test_divu_stall;
        test_div_signed;
        test_multu_req;
        test_reset_midflight;
        test_mthi_mtlo;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
